// File: rtl/board_io_pkg.sv
// Shared constants for the board input PIO: CSR word offsets, data width and channel limit.
package board_io_pkg;

  localparam int CSR_W  = 32;
  localparam int MAX_CH = 32;

  localparam logic [1:0] DATA_OFS = 2'd0;
  localparam logic [1:0] EDGE_OFS = 2'd1;
  localparam logic [1:0] MASK_OFS = 2'd2;
  localparam logic [1:0] RAW_OFS  = 2'd3;

endpackage

// File: rtl/debounce_ch.sv
// One input channel: 2-FF synchronizer, polarity fix-up and stability counter.
// take pulses high in the cycle whose clock edge loads sync into stable.
module debounce_ch #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic INVERT          = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic sync,
  output logic stable,
  output logic take
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_r;
  logic             sync_r;
  logic             stable_r;
  logic [CNT_W-1:0] cnt_r;
  logic             take_s;

  // Inversion sits ahead of the first flop so a cleared synchronizer means
  // "inactive" and an idle active-low key does not start a count out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= pin ^ INVERT;
      sync_r <= meta_r;
    end
  end

  assign take_s = (sync_r != stable_r) && (cnt_r == CNT_MAX);

  // Stability counter: restarts whenever input matches stable, saturates into a take.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_r <= 1'b0;
      cnt_r    <= '0;
    end else if (sync_r == stable_r) begin
      cnt_r    <= '0;
    end else if (take_s) begin
      stable_r <= sync_r;
      cnt_r    <= '0;
    end else begin
      cnt_r    <= cnt_r + CNT_W'(1);
    end
  end

  assign sync   = sync_r;
  assign stable = stable_r;
  assign take   = take_s;

endmodule

// File: rtl/board_input_pio.sv
// Debounced board input PIO with Avalon-MM CSRs and a level interrupt.
// Define INPUT_PIO_BOTH_EDGES_EN to latch edge events on release as well as press.
module board_input_pio
  import board_io_pkg::*;
#(
  parameter int              N_CH            = 14,
  parameter int              DEBOUNCE_CYCLES = 50000,
  parameter logic [N_CH-1:0] INVERT_MASK     = 14'h3C00
) (
  input  logic            clk_clk,
  input  logic            reset_reset_n,
  input  logic [N_CH-1:0] pins_export,
  input  logic [1:0]      address,
  input  logic            read,
  input  logic            write,
  input  logic [31:0]     writedata,
  output logic [31:0]     readdata,
  output logic            irq
);

  logic [N_CH-1:0]  sync_s;
  logic [N_CH-1:0]  stable_s;
  logic [N_CH-1:0]  take_s;
  logic [N_CH-1:0]  ev_s;
  logic [N_CH-1:0]  w1c_s;
  logic [N_CH-1:0]  edge_r;
  logic [N_CH-1:0]  mask_r;
  logic [CSR_W-1:0] rd_mux_s;
  logic [CSR_W-1:0] readdata_r;
  logic             irq_r;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .INVERT          (INVERT_MASK[i])
    ) u_ch (
      .clk    (clk_clk),
      .rst_n  (reset_reset_n),
      .pin    (pins_export[i]),
      .sync   (sync_s[i]),
      .stable (stable_s[i]),
      .take   (take_s[i])
    );
  end

  // Edge event: a take whose new stable value is 1 is a press.
  always_comb begin
`ifdef INPUT_PIO_BOTH_EDGES_EN
    ev_s = take_s;
`else
    ev_s = take_s & sync_s;
`endif
  end

  // Write-1-to-clear mask for the EDGE register.
  always_comb begin
    if (write && (address == EDGE_OFS)) begin
      w1c_s = writedata[N_CH-1:0];
    end else begin
      w1c_s = '0;
    end
  end

  // CSR read mux; unused upper bits stay zero.
  always_comb begin
    rd_mux_s = '0;
    case (address)
      DATA_OFS: rd_mux_s[N_CH-1:0] = stable_s;
      EDGE_OFS: rd_mux_s[N_CH-1:0] = edge_r;
      MASK_OFS: rd_mux_s[N_CH-1:0] = mask_r;
      RAW_OFS:  rd_mux_s[N_CH-1:0] = sync_s;
      default:  rd_mux_s = '0;
    endcase
  end

  // Edge capture: a new event outranks a same-cycle clear.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      edge_r <= '0;
    end else begin
      edge_r <= (edge_r & ~w1c_s) | ev_s;
    end
  end

  // Interrupt mask register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      mask_r <= '0;
    end else if (write && (address == MASK_OFS)) begin
      mask_r <= writedata[N_CH-1:0];
    end else begin
      mask_r <= mask_r;
    end
  end

  // Read data and interrupt are registered; reads see pre-write register values.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      readdata_r <= '0;
      irq_r      <= 1'b0;
    end else begin
      if (read) begin
        readdata_r <= rd_mux_s;
      end else begin
        readdata_r <= readdata_r;
      end
      irq_r <= |(edge_r & mask_r);
    end
  end

  assign readdata = readdata_r;
  assign irq      = irq_r;

endmodule

// File: tb/tb_board_input_pio.sv
// Directed bench for board_input_pio with N_CH=14, DEBOUNCE_CYCLES=4, INVERT_MASK=14'h3C00.
module tb_board_input_pio;

  logic        clk;
  logic        rst_n;
  logic [13:0] pins;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  int n_asrt = 0;
  int n_fail = 0;
  logic [31:0] rd;

  board_input_pio #(
    .N_CH            (14),
    .DEBOUNCE_CYCLES (4),
    .INVERT_MASK     (14'h3C00)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .pins_export   (pins),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .readdata      (readdata),
    .irq           (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    read    = 1'b1;
    tick(1);
    read    = 1'b0;
    d       = readdata;
  endtask

  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    tick(1);
    write     = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    pins      = 14'h3C00;
    address   = 2'd0;
    read      = 1'b0;
    write     = 1'b0;
    writedata = 32'h0;
    @(negedge clk);

    // Reset held 5 cycles with keys idle high
    tick(5);
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    rst_n = 1'b1;
    tick(6);
    csr_read(2'd0, rd);
    check("idle_data", rd, 32'h0);
    csr_read(2'd3, rd);
    check("idle_raw", rd, 32'h0);

    // pin0 rises; stable loads on the 6th edge, so a held read shows it after the 7th
    pins[0] = 1'b1;
    address = 2'd0;
    read    = 1'b1;
    tick(6);
    check("deb_before", readdata, 32'h0);
    tick(1);
    check("deb_exact", readdata, 32'h1);
    read = 1'b0;
    csr_write(2'd1, 32'h1);
    csr_read(2'd1, rd);
    check("w1c_clear", rd, 32'h0);

    // 3-cycle glitch on pin1 must be rejected
    pins[1] = 1'b1;
    tick(3);
    pins[1] = 1'b0;
    tick(10);
    csr_read(2'd0, rd);
    check("glitch_data", rd, 32'h1);
    csr_read(2'd1, rd);
    check("glitch_edge", rd, 32'h0);

    // Active-low key press on pin10 with interrupt enabled
    csr_write(2'd2, 32'h0400);
    csr_read(2'd2, rd);
    check("mask_rw", rd, 32'h0400);
    pins[10] = 1'b0;
    tick(6);
    check("irq_lag", {31'h0, irq}, 32'h0);
    tick(1);
    check("irq_set", {31'h0, irq}, 32'h1);
    csr_read(2'd1, rd);
    check("key_edge", rd, 32'h0400);
    csr_write(2'd1, 32'h0400);
    check("irq_hold", {31'h0, irq}, 32'h1);
    tick(1);
    check("irq_clr", {31'h0, irq}, 32'h0);
    csr_read(2'd1, rd);
    check("key_edge_clr", rd, 32'h0);

    // Release of pin0: only latched when both edges are enabled
    pins[0] = 1'b0;
    tick(8);
    csr_read(2'd1, rd);
`ifdef INPUT_PIO_BOTH_EDGES_EN
    check("release_edge", rd, 32'h1);
`else
    check("release_edge", rd, 32'h0);
`endif
    csr_write(2'd1, 32'h1);

    // W1C of bit 0 lands on the same edge as a new press of pin0
    pins[0] = 1'b1;
    tick(5);
    csr_write(2'd1, 32'h1);
    csr_read(2'd1, rd);
    check("collision", rd, 32'h1);
    check("irq_masked", {31'h0, irq}, 32'h0);

    // pin2 mid-bounce (count 2), then a 1-cycle reset; reset acts without a clock edge
    pins[2] = 1'b1;
    tick(4);
    rst_n = 1'b0;
    #1;
    check("async_readdata", readdata, 32'h0);
    check("async_irq", {31'h0, irq}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    address = 2'd0;
    read    = 1'b1;
    tick(6);
    check("restart_before", readdata, 32'h0);
    tick(1);
    check("restart_exact", readdata, 32'h0405);
    read = 1'b0;
    csr_read(2'd2, rd);
    check("restart_mask", rd, 32'h0);
    csr_read(2'd1, rd);
    check("restart_edge", rd, 32'h0405);
    check("restart_irq", {31'h0, irq}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
